// File: rtl/alu_nbit_seq.sv
// Multi-cycle N-bit ALU: single-cycle add/sub/logic ops, iterative shift-add multiply
// and restoring divide. Outputs are registered and change only when done pulses.
module alu_nbit_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op_select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             cout,
    output logic             overflow,
    output logic             neg,
    output logic             zero,
    output logic             div_zero,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start; operands latched on accept
    // MUL   | one shift-add partial product per cycle, WIDTH cycles
    // DIV   | one restoring quotient bit per cycle, WIDTH cycles
    // DONE  | done pulse cycle; start ignored, returns to IDLE

    localparam int            MSB      = WIDTH - 1;
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     opa;
    logic [WIDTH-1:0]     opb;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic [2*WIDTH-1:0]   prod;
    logic [CW-1:0]        cnt;

    logic [WIDTH:0]       add_full;
    logic [WIDTH:0]       sub_full;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_cout;
    logic                 alu_ovf;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_fit;
    logic [WIDTH-1:0]     rem_next;
    logic [WIDTH-1:0]     quo_next;

    logic                 fin_valid;
    logic [WIDTH-1:0]     fin_res;
    logic [WIDTH-1:0]     fin_rem;
    logic                 fin_cout;
    logic                 fin_ovf;
    logic                 fin_dz;

    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (op_select)
            3'b000: begin
                alu_res  = add_full[MSB:0];
                alu_cout = add_full[WIDTH];
                alu_ovf  = (a[MSB] == b[MSB]) && (add_full[MSB] != a[MSB]);
            end
            3'b001: begin
                alu_res  = sub_full[MSB:0];
                alu_cout = sub_full[WIDTH];
                alu_ovf  = (a[MSB] != b[MSB]) && (sub_full[MSB] != a[MSB]);
            end
            3'b010:  alu_res = a & b;
            3'b011:  alu_res = a | b;
            3'b110:  alu_res = a ^ b;
            default: alu_res = '0;
        endcase
    end

    // Multiplier sits in the low half of prod and is shifted out as the sum moves in.
    assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, prod[WIDTH-1:1]};

    // rem < divisor always holds, so the borrow bit alone decides the quotient bit.
    assign div_shift = {rem, quo[MSB]};
    assign div_diff  = div_shift - {1'b0, opb};
    assign div_fit   = ~div_diff[WIDTH];
    assign rem_next  = div_fit ? div_diff[MSB:0] : div_shift[MSB:0];
    assign quo_next  = {quo[MSB-1:0], div_fit};

    always_comb begin
        fin_valid = 1'b0;
        fin_res   = alu_res;
        fin_rem   = '0;
        fin_cout  = alu_cout;
        fin_ovf   = alu_ovf;
        fin_dz    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op_select == 3'b101) begin
                        if (b == '0) begin
                            fin_valid = 1'b1;
                            fin_res   = '1;
                            fin_rem   = a;
                            fin_cout  = 1'b0;
                            fin_ovf   = 1'b0;
                            fin_dz    = 1'b1;
                        end
                    end else if (op_select != 3'b100) begin
                        fin_valid = 1'b1;
                    end
                end
            end
            MUL: begin
                fin_valid = (cnt == CNT_LAST);
                fin_res   = mul_next[MSB:0];
                fin_cout  = 1'b0;
                fin_ovf   = |mul_next[2*WIDTH-1:WIDTH];
            end
            DIV: begin
                fin_valid = (cnt == CNT_LAST);
                fin_res   = quo_next;
                fin_rem   = rem_next;
                fin_cout  = 1'b0;
                fin_ovf   = 1'b0;
            end
            default: fin_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            result    <= '0;
            remainder <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            neg       <= 1'b0;
            zero      <= 1'b1;
            div_zero  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            quo       <= '0;
            rem       <= '0;
            prod      <= '0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            if (fin_valid) begin
                result    <= fin_res;
                remainder <= fin_rem;
                cout      <= fin_cout;
                overflow  <= fin_ovf;
                neg       <= fin_res[MSB];
                zero      <= (fin_res == '0);
                div_zero  <= fin_dz;
                busy      <= 1'b0;
                done      <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        opa  <= a;
                        opb  <= b;
                        cnt  <= CNT_LOAD;
                        prod <= {{WIDTH{1'b0}}, b};
                        quo  <= a;
                        rem  <= '0;
                        if (op_select == 3'b100) begin
                            state <= MUL;
                            busy  <= 1'b1;
                        end else if ((op_select == 3'b101) && (b != '0)) begin
                            state <= DIV;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                MUL: begin
                    prod <= mul_next;
                    cnt  <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) state <= DONE;
                end
                DIV: begin
                    quo <= quo_next;
                    rem <= rem_next;
                    cnt <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
